led_sequencer: RTL and testbench

- Parametrised LED/7-segment pattern sequencer for the study board; next generation of the fixed alternating blinker.
- Divides the system clock to a programmable step rate and drives NUM_LEDS discrete LEDs in one of four selectable modes.
- Animates NUM_DIGITS active-low 7-segment digits with a rotating segment ring.
- Adds pause and a step-tick output for other board-level blocks.

---
 rtl/led_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_led_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// ============================================================================
// Module   : led_sequencer
// Brief    : Step-rate LED pattern sequencer with rotating 7-segment ring.
// Revision : 1.0 - first release of the parametrised sequencer
// ============================================================================
`default_nettype none

module led_sequencer #(
  parameter int CLK_HZ     = 10000000,
  parameter int STEP_HZ    = 4,
  parameter int NUM_LEDS   = 16,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic                    pause,
  output logic [NUM_LEDS-1:0]     led,
  output logic [8*NUM_DIGITS-1:0] hex,
  output logic                    tick
);

  localparam int C_DIV   = CLK_HZ / STEP_HZ;
  localparam int C_CNT_W = (C_DIV > 1) ? $clog2(C_DIV) : 1;
  localparam int C_POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int C_LVL_W = $clog2(NUM_LEDS + 1);

  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_DIV - 1);
  localparam logic [C_POS_W-1:0] C_POS_LAST = C_POS_W'(NUM_LEDS - 1);
  localparam logic [C_POS_W-1:0] C_POS_TURN = C_POS_W'((NUM_LEDS > 1) ? NUM_LEDS - 2 : 0);
  localparam logic [C_LVL_W-1:0] C_LVL_FULL = C_LVL_W'(NUM_LEDS);
  localparam logic [2:0]         C_RING_LAST = 3'd5;

  typedef enum logic [1:0] {
    MODE_ALT    = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BAR    = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [C_CNT_W-1:0]      count_q, count_d;
  logic                    tick_q, tick_d;
  logic [NUM_LEDS-1:0]     led_q, led_d;
  logic [8*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [C_POS_W-1:0]      pos_q, pos_d;
  dir_e                    dir_q, dir_d;
  logic                    phase_q, phase_d;
  logic [C_LVL_W-1:0]      lvl_q, lvl_d;
  logic [2:0]              ring_q, ring_d;
  mode_e                   mode_q, mode_d;

  logic                    phase_next;
  logic [C_LVL_W-1:0]      lvl_next;
  logic [2:0]              ring_next;
  logic [NUM_LEDS-1:0]     alt_pat;
  logic [NUM_LEDS-1:0]     onehot_pat;
  logic [NUM_LEDS-1:0]     bar_pat;
  logic [8*NUM_DIGITS-1:0] ring_hex;

  assign phase_next = ~phase_q;
  assign lvl_next   = (lvl_q == C_LVL_FULL) ? '0 : lvl_q + 1'b1;
  assign ring_next  = (ring_q == C_RING_LAST) ? 3'd0 : ring_q + 3'd1;

  // Per-LED pattern candidates; the step logic only selects between them.
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
    if (i % 2 == 0) begin : g_even
      assign alt_pat[i] = phase_next;
    end else begin : g_odd
      assign alt_pat[i] = ~phase_next;
    end
    assign onehot_pat[i] = (pos_q == C_POS_W'(i));
    assign bar_pat[i]    = (C_LVL_W'(i) < lvl_next);
  end

  // Digit k lights segment (ring_next + k) mod 6, folded without a divider.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    localparam logic [3:0] C_OFF = 4'(k % 6);
    logic [3:0] seg_sum;
    logic [2:0] seg_sel;
    assign seg_sum = {1'b0, ring_next} + C_OFF;
    assign seg_sel = (seg_sum >= 4'd6) ? 3'(seg_sum - 4'd6) : seg_sum[2:0];
    assign ring_hex[8*k +: 8] = ~(8'h01 << seg_sel);
  end

  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    led_d   = led_q;
    hex_d   = hex_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    lvl_d   = lvl_q;
    ring_d  = ring_q;
    mode_d  = mode_q;

    if (!pause) begin
      if (count_q == C_CNT_LAST) begin
        count_d = '0;
        tick_d  = 1'b1;
        ring_d  = ring_next;
        hex_d   = ring_hex;

        if (mode_e'(mode) != mode_q) begin
          // A mode change restarts the pattern and shows one blank step.
          mode_d  = mode_e'(mode);
          pos_d   = '0;
          dir_d   = DIR_UP;
          phase_d = 1'b0;
          lvl_d   = '0;
          led_d   = '0;
        end else begin
          unique case (mode_q)
            MODE_ALT: begin
              phase_d = phase_next;
              led_d   = alt_pat;
            end
            MODE_CHASE: begin
              led_d = onehot_pat;
              pos_d = (pos_q == C_POS_LAST) ? '0 : pos_q + 1'b1;
            end
            MODE_BOUNCE: begin
              led_d = onehot_pat;
              if (NUM_LEDS == 1) begin
                pos_d = '0;
              end else if (dir_q == DIR_UP) begin
                if (pos_q == C_POS_LAST) begin
                  dir_d = DIR_DOWN;
                  pos_d = C_POS_TURN;
                end else begin
                  pos_d = pos_q + 1'b1;
                end
              end else begin
                if (pos_q == '0) begin
                  dir_d = DIR_UP;
                  pos_d = C_POS_W'(1);
                end else begin
                  pos_d = pos_q - 1'b1;
                end
              end
            end
            MODE_BAR: begin
              lvl_d = lvl_next;
              led_d = bar_pat;
            end
            default: ;
          endcase
        end
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tick_q  <= 1'b0;
      led_q   <= '0;
      hex_q   <= '1;
      pos_q   <= '0;
      dir_q   <= DIR_UP;
      phase_q <= 1'b0;
      lvl_q   <= '0;
      ring_q  <= 3'd0;
      mode_q  <= mode_e'(mode);
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      led_q   <= led_d;
      hex_q   <= hex_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      lvl_q   <= lvl_d;
      ring_q  <= ring_d;
      mode_q  <= mode_d;
    end
  end

  assign led  = led_q;
  assign hex  = hex_q;
  assign tick = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_led_sequencer.sv
// ============================================================================
// Module   : tb_led_sequencer
// Brief    : Self-checking bench for led_sequencer against a step-count model.
// Revision : 1.0 - first release
// ============================================================================
`default_nettype none

module tb_led_sequencer;

  localparam int DIV = 8;
  localparam int N   = 16;
  localparam int ND  = 6;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic [1:0]    mode  = 2'd0;
  logic          pause = 1'b0;
  logic [N-1:0]  led;
  logic [8*ND-1:0] hex;
  logic          tick;

  led_sequencer #(
    .CLK_HZ    (8),
    .STEP_HZ   (1),
    .NUM_LEDS  (N),
    .NUM_DIGITS(ND)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .pause(pause),
    .led  (led),
    .hex  (hex),
    .tick (tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: the pattern is a pure function of how many steps the current
  // mode has been running; the ring is a function of steps since reset.
  int              m_cnt    = 0;
  logic            m_tick   = 1'b0;
  logic [N-1:0]    m_led    = '0;
  logic [8*ND-1:0] m_hex    = '1;
  int              m_steps  = 0;
  int              m_k      = 0;
  logic [1:0]      m_active = 2'd0;

  function automatic logic [N-1:0] pattern(input logic [1:0] md, input int k);
    int p, idx, lvl;
    case (md)
      2'd0: return (k % 2 == 1) ? 16'h5555 : 16'hAAAA;
      2'd1: return 16'(32'(1) << ((k - 1) % N));
      2'd2: begin
        p   = (k - 1) % (2 * N - 2);
        idx = (p < N) ? p : (2 * N - 2 - p);
        return 16'(32'(1) << idx);
      end
      default: begin
        lvl = k % (N + 1);
        return 16'((32'(1) << lvl) - 1);
      end
    endcase
  endfunction

  function automatic logic [8*ND-1:0] ring_hex(input int s);
    logic [8*ND-1:0] h;
    for (int d = 0; d < ND; d++) h[8*d +: 8] = ~(8'h01 << ((s + d) % 6));
    return h;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_cnt = 0; m_tick = 1'b0; m_led = '0; m_hex = '1;
      m_steps = 0; m_k = 0; m_active = mode;
    end else if (pause) begin
      m_tick = 1'b0;
    end else if (m_cnt == DIV - 1) begin
      m_cnt = 0; m_tick = 1'b1;
      m_steps++;
      m_hex = ring_hex(m_steps);
      if (mode != m_active) begin
        m_active = mode; m_k = 0; m_led = '0;
      end else begin
        m_k++;
        m_led = pattern(m_active, m_k);
      end
    end else begin
      m_cnt++; m_tick = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("led", 64'(led), 64'(m_led));
    chk("hex", 64'(hex), 64'(m_hex));
    chk("tick", 64'(tick), 64'(m_tick));
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      do begin
        cycle();
        guard++;
      end while (!m_tick && guard < 4 * DIV);
      if (!m_tick) chk("tick_timeout", 64'(0), 64'(1));
    end
  endtask

  task automatic do_reset(input logic [1:0] md);
    rst = 1'b1; mode = md; pause = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;
  endtask

  task automatic cycles_to_tick(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!tick && n < 4 * DIV);
  endtask

  logic [7:0] ring_d0_exp [7] = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hFE, 8'hFD};

  initial begin
    int n;
    logic [N-1:0]    led_hold;
    logic [8*ND-1:0] hex_hold;

    // Reset state and divider timing
    do_reset(2'd0);
    chk("rst_led", 64'(led), 64'(0));
    chk("rst_hex", 64'(hex), 64'(48'hFFFF_FFFF_FFFF));
    chk("rst_tick", 64'(tick), 64'(0));
    cycles_to_tick(n);
    chk("first_tick_latency", 64'(n), 64'(8));
    chk("alt_first", 64'(led), 64'(16'h5555));
    cycle();
    chk("tick_width", 64'(tick), 64'(0));
    cycles_to_tick(n);
    chk("tick_period", 64'(n + 1), 64'(8));
    chk("alt_second", 64'(led), 64'(16'hAAAA));

    // Chase wrap
    do_reset(2'd1);
    run_ticks(16);
    chk("chase_16", 64'(led), 64'(16'h8000));
    run_ticks(1);
    chk("chase_17", 64'(led), 64'(16'h0001));

    // Bounce endpoints
    do_reset(2'd2);
    run_ticks(16);
    chk("bounce_top", 64'(led), 64'(16'h8000));
    run_ticks(1);
    chk("bounce_turn_down", 64'(led), 64'(16'h4000));
    run_ticks(14);
    chk("bounce_bottom", 64'(led), 64'(16'h0001));
    run_ticks(1);
    chk("bounce_turn_up", 64'(led), 64'(16'h0002));

    // Bar fill then a mid-interval switch to chase
    do_reset(2'd3);
    run_ticks(16);
    chk("bar_full", 64'(led), 64'(16'hFFFF));
    run_ticks(1);
    chk("bar_empty", 64'(led), 64'(16'h0000));
    run_ticks(1);
    chk("bar_restart", 64'(led), 64'(16'h0001));
    repeat (3) cycle();
    mode = 2'd1;
    run_ticks(1);
    chk("switch_blank", 64'(led), 64'(16'h0000));
    run_ticks(1);
    chk("switch_first", 64'(led), 64'(16'h0001));

    // Pause at count 5
    n = 0;
    while (m_cnt != 5 && n < 4 * DIV) begin cycle(); n++; end
    chk("pause_reach_5", 64'(m_cnt), 64'(5));
    led_hold = led; hex_hold = hex;
    pause = 1'b1;
    repeat (20) cycle();
    chk("pause_led_hold", 64'(led), 64'(led_hold));
    chk("pause_hex_hold", 64'(hex), 64'(hex_hold));
    pause = 1'b0;
    cycles_to_tick(n);
    chk("pause_resume_latency", 64'(n), 64'(3));

    // Segment ring, then reset on a tick edge
    do_reset(2'd0);
    for (int t = 0; t < 7; t++) begin
      run_ticks(1);
      chk("ring_digit0", 64'(hex[7:0]), 64'(ring_d0_exp[t]));
    end
    n = 0;
    while (m_cnt != DIV - 1 && n < 4 * DIV) begin cycle(); n++; end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_on_tick_tick", 64'(tick), 64'(0));
    chk("rst_on_tick_led", 64'(led), 64'(0));
    chk("rst_on_tick_hex", 64'(hex), 64'(48'hFFFF_FFFF_FFFF));

    // Randomised soak
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      pause = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
